mips_decode_exec: RTL and testbench

Combined main-decoder and execute unit for the 5-stage MIPS pipeline. Decodes the ID-stage opcode into branch/jump/flush signals and an 8-bit pipeline control word, registers the ALU-relevant control into the EX stage, and computes the EX-stage ALU result from the registered ALUOp plus the immediate's funct field. Sits between IF/ID (opcode in) and EX/MEM (result and control out); the hazard unit, forwarding muxes and register file are outside.

---
 rtl/mips_decode_exec_pkg.sv | 62 ++++++
 rtl/mips_decode_exec_alu_core.sv | 55 +++++
 rtl/mips_decode_exec.sv | 122 ++++++++++++
 tb/tb_mips_decode_exec.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_decode_exec_pkg.sv
// Shared constants for mips_decode_exec: opcodes, funct codes,
// ALU operation codes, ALUOp encodings and control-word bit indices.
package mips_decode_exec_pkg;

  // Main opcodes (Ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (Ins[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALUOp field of the control word
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_AND   = 2'b11
  } alu_op_e;

  // Control-word bit positions
  localparam int CS_REG_WRITE = 7;
  localparam int CS_MEM_TO_REG = 6;
  localparam int CS_MEM_READ = 5;
  localparam int CS_MEM_WRITE = 4;
  localparam int CS_REG_DST = 3;
  localparam int CS_ALUOP_HI = 2;
  localparam int CS_ALUOP_LO = 1;
  localparam int CS_ALU_SRC = 0;

  // Control words per instruction class
  localparam logic [7:0] CTRL_RTYPE = 8'b1000_1100;
  localparam logic [7:0] CTRL_LW    = 8'b1110_0001;
  localparam logic [7:0] CTRL_SW    = 8'b0001_0001;
  localparam logic [7:0] CTRL_BR    = 8'b0000_0010;
  localparam logic [7:0] CTRL_ADDI  = 8'b1000_0001;
  localparam logic [7:0] CTRL_ANDI  = 8'b1000_0111;
  localparam logic [7:0] CTRL_NONE  = 8'b0000_0000;

endpackage

// File: rtl/mips_decode_exec_alu_core.sv
// alu_core: combinational 32-bit ALU. Ports: a, b, code -> result, zero
// and, when MIPS_DECODE_EXEC_OVF_EN is defined, overflow (add/sub only).
module alu_core
  import mips_decode_exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  code,
  output logic [31:0] result,
  output logic        zero
`ifdef MIPS_DECODE_EXEC_OVF_EN
  ,
  output logic        overflow
`endif
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt;

  assign sum  = a + b;
  assign diff = a - b;
  // Native signed compare stays correct where a-b overflows.
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    result = sum;
    case (code)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = diff;
      ALU_SLT: result = {31'd0, lt};
      ALU_NOR: result = ~(a | b);
      default: result = sum;
    endcase
  end

  assign zero = (result == 32'd0);

`ifdef MIPS_DECODE_EXEC_OVF_EN
  always_comb begin
    overflow = 1'b0;
    case (code)
      ALU_ADD: overflow = (a[31] == b[31])
                        & (sum[31] != a[31]);
      ALU_SUB: overflow = (a[31] != b[31])
                        & (diff[31] != a[31]);
      default: overflow = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/mips_decode_exec.sv
// mips_decode_exec: ID main decoder, EX control register, ALU control and
// ALU. Ports: clk, reset, opcode_id, equal, stall, nop, alu_a, alu_b,
// imm_ex in; jump, branch, bne, if_flush, ctrl_sig, wb_sig_ex, m_sig_ex,
// reg_dst_ex, alu_ctrl, alu_result, zero out; overflow out when
// MIPS_DECODE_EXEC_OVF_EN is defined.
module mips_decode_exec
  import mips_decode_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_id,
  input  logic        equal,
  input  logic        stall,
  input  logic        nop,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [31:0] imm_ex,
  output logic        jump,
  output logic        branch,
  output logic        bne,
  output logic        if_flush,
  output logic [7:0]  ctrl_sig,
  output logic [1:0]  wb_sig_ex,
  output logic [1:0]  m_sig_ex,
  output logic        reg_dst_ex,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero
`ifdef MIPS_DECODE_EXEC_OVF_EN
  ,
  output logic        overflow
`endif
);

  logic [7:0]  ex_q;
  logic [31:0] op2;
  alu_op_e     alu_op;

  // Main decoder
  always_comb begin
    ctrl_sig = CTRL_NONE;
    jump     = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    unique case (1'b1)
      (opcode_id == OP_RTYPE): ctrl_sig = CTRL_RTYPE;
      (opcode_id == OP_LW):    ctrl_sig = CTRL_LW;
      (opcode_id == OP_SW):    ctrl_sig = CTRL_SW;
      (opcode_id == OP_ADDI):  ctrl_sig = CTRL_ADDI;
      (opcode_id == OP_ANDI):  ctrl_sig = CTRL_ANDI;
      (opcode_id == OP_BEQ): begin
        ctrl_sig = CTRL_BR;
        branch   = 1'b1;
      end
      (opcode_id == OP_BNE): begin
        ctrl_sig = CTRL_BR;
        bne      = 1'b1;
      end
      (opcode_id == OP_J):     jump = 1'b1;
      default: ;
    endcase
  end

  // A stalled IF/ID must keep its instruction, so no flush then.
  assign if_flush = ~stall
                  & (jump
                  | (branch & equal)
                  | (bne & ~equal));

  // EX control register
  always_ff @(posedge clk) begin
    if (reset) ex_q <= 8'h00;
    else if (nop) ex_q <= 8'h00;
    else ex_q <= ctrl_sig;
  end

  assign wb_sig_ex  = {ex_q[CS_REG_WRITE],
                       ex_q[CS_MEM_TO_REG]};
  assign m_sig_ex   = {ex_q[CS_MEM_READ],
                       ex_q[CS_MEM_WRITE]};
  assign reg_dst_ex = ex_q[CS_REG_DST];
  assign alu_op     = alu_op_e'(
    ex_q[CS_ALUOP_HI:CS_ALUOP_LO]);

  // ALU control
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      AOP_AND: alu_ctrl = ALU_AND;
      AOP_FUNCT: begin
        case (imm_ex[5:0])
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign op2 = ex_q[CS_ALU_SRC] ? imm_ex : alu_b;

  alu_core u_alu (
    .a        (alu_a),
    .b        (op2),
    .code     (alu_ctrl),
    .result   (alu_result),
    .zero     (zero)
`ifdef MIPS_DECODE_EXEC_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

endmodule

// File: tb/tb_mips_decode_exec.sv
// Testbench for mips_decode_exec: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_mips_decode_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode_id;
  logic        equal;
  logic        stall;
  logic        nop;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] imm_ex;
  logic        jump;
  logic        branch;
  logic        bne;
  logic        if_flush;
  logic [7:0]  ctrl_sig;
  logic [1:0]  wb_sig_ex;
  logic [1:0]  m_sig_ex;
  logic        reg_dst_ex;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
`ifdef MIPS_DECODE_EXEC_OVF_EN
  logic        overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_decode_exec dut (
    .clk        (clk),
    .reset      (reset),
    .opcode_id  (opcode_id),
    .equal      (equal),
    .stall      (stall),
    .nop        (nop),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .imm_ex     (imm_ex),
    .jump       (jump),
    .branch     (branch),
    .bne        (bne),
    .if_flush   (if_flush),
    .ctrl_sig   (ctrl_sig),
    .wb_sig_ex  (wb_sig_ex),
    .m_sig_ex   (m_sig_ex),
    .reg_dst_ex (reg_dst_ex),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .zero       (zero)
`ifdef MIPS_DECODE_EXEC_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00: return 8'h8C;
      6'h23: return 8'hE1;
      6'h2B: return 8'h11;
      6'h04: return 8'h02;
      6'h05: return 8'h02;
      6'h08: return 8'h81;
      6'h0C: return 8'h87;
      default: return 8'h00;
    endcase
  endfunction

  // Operation name chosen by the instruction: 0 add,1 sub,2 and,3 or,
  // 4 xor,5 nor,6 slt
  function automatic int m_kind(input logic [7:0] c,
                                input logic [5:0] fn);
    case (c[2:1])
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: begin
        case (fn)
          6'h22, 6'h23: return 1;
          6'h24: return 2;
          6'h25: return 3;
          6'h26: return 4;
          6'h27: return 5;
          6'h2A: return 6;
          default: return 0;
        endcase
      end
    endcase
  endfunction

  function automatic logic [3:0] m_code(input int k);
    case (k)
      1: return 4'b0110;
      2: return 4'b0000;
      3: return 4'b0001;
      4: return 4'b0011;
      5: return 4'b1100;
      6: return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input int k,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return (sa < sb) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic m_ovf(input int k,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    longint r;
    if (k == 0) r = longint'($signed(a)) + longint'($signed(b));
    else if (k == 1) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic m_flush(input logic [5:0] op,
                                   input logic eq,
                                   input logic st);
    logic taken;
    taken = (op == 6'h02) || (op == 6'h04 && eq)
         || (op == 6'h05 && !eq);
    return taken && !st;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; nop = 1'b0; opcode_id = 6'h23;
    equal = 1'b0; stall = 1'b0;
    alu_a = 32'd5; alu_b = 32'd3; imm_ex = 32'h1234_5678;
    @(posedge clk); #1;
    reset = 1'b0;
    opcode_id = 6'h3F;
    #1;
    checks++;
    if (wb_sig_ex !== 2'b00) begin
      errors++;
      $display("FAIL reset_wb got=%b exp=00", wb_sig_ex);
    end
    checks++;
    if (m_sig_ex !== 2'b00) begin
      errors++;
      $display("FAIL reset_m got=%b exp=00", m_sig_ex);
    end
    checks++;
    if (alu_result !== 32'd8) begin
      errors++;
      $display("FAIL reset_alu got=%h exp=8", alu_result);
    end
    checks++;
    if (reg_dst_ex !== 1'b0) begin
      errors++;
      $display("FAIL reset_regdst got=%b exp=0", reg_dst_ex);
    end
  endtask

  task automatic test_lw();
    opcode_id = 6'h23; nop = 1'b0;
    #1;
    checks++;
    if (ctrl_sig !== 8'hE1) begin
      errors++;
      $display("FAIL lw_ctrl got=%h exp=e1", ctrl_sig);
    end
    @(posedge clk); #1;
    imm_ex = 32'h10; alu_a = 32'h100; alu_b = 32'hDEAD_BEEF;
    opcode_id = 6'h3F;
    #1;
    checks++;
    if (m_sig_ex !== 2'b10) begin
      errors++;
      $display("FAIL lw_m got=%b exp=10", m_sig_ex);
    end
    checks++;
    if (alu_result !== 32'h110) begin
      errors++;
      $display("FAIL lw_alu got=%h exp=110", alu_result);
    end
  endtask

  task automatic test_rtype();
    opcode_id = 6'h00; nop = 1'b0;
    @(posedge clk); #1;
    opcode_id = 6'h00;
    imm_ex = 32'h2A; alu_a = 32'h8000_0000; alu_b = 32'h7FFF_FFFF;
    #1;
    checks++;
    if (alu_ctrl !== 4'b0111) begin
      errors++;
      $display("FAIL slt_ctrl got=%b exp=0111", alu_ctrl);
    end
    checks++;
    if (alu_result !== 32'd1) begin
      errors++;
      $display("FAIL slt_ovf got=%h exp=1", alu_result);
    end
    checks++;
    if (reg_dst_ex !== 1'b1) begin
      errors++;
      $display("FAIL rtype_regdst got=%b exp=1", reg_dst_ex);
    end
    @(posedge clk); #1;
    imm_ex = 32'h22; alu_a = 32'd3; alu_b = 32'd5;
    #1;
    checks++;
    if (alu_result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sub_neg got=%h exp=fffffffe", alu_result);
    end
    alu_a = 32'd5;
    #1;
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero got=%b exp=1", zero);
    end
  endtask

  task automatic test_branch();
    opcode_id = 6'h04; equal = 1'b1; stall = 1'b0;
    #1;
    checks++;
    if (branch !== 1'b1 || if_flush !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken got=%b%b exp=11", branch, if_flush);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (if_flush !== 1'b0) begin
      errors++;
      $display("FAIL beq_stall got=%b exp=0", if_flush);
    end
    opcode_id = 6'h05; stall = 1'b0; equal = 1'b1;
    #1;
    checks++;
    if (bne !== 1'b1 || if_flush !== 1'b0) begin
      errors++;
      $display("FAIL bne_eq got=%b%b exp=10", bne, if_flush);
    end
    equal = 1'b0;
    #1;
    checks++;
    if (if_flush !== 1'b1) begin
      errors++;
      $display("FAIL bne_ne got=%b exp=1", if_flush);
    end
    opcode_id = 6'h02;
    #1;
    checks++;
    if (jump !== 1'b1 || if_flush !== 1'b1) begin
      errors++;
      $display("FAIL jump got=%b%b exp=11", jump, if_flush);
    end
    checks++;
    if (ctrl_sig !== 8'h00) begin
      errors++;
      $display("FAIL jump_ctrl got=%h exp=00", ctrl_sig);
    end
  endtask

  task automatic test_nop();
    opcode_id = 6'h08; nop = 1'b1; stall = 1'b0;
    #1;
    checks++;
    if (ctrl_sig !== 8'h81) begin
      errors++;
      $display("FAIL addi_ctrl got=%h exp=81", ctrl_sig);
    end
    @(posedge clk); #1;
    nop = 1'b0; opcode_id = 6'h3F;
    alu_a = 32'd10; alu_b = 32'd20; imm_ex = 32'd1000;
    #1;
    checks++;
    if (wb_sig_ex !== 2'b00 || m_sig_ex !== 2'b00) begin
      errors++;
      $display("FAIL nop_bubble got=%b%b exp=0000",
               wb_sig_ex, m_sig_ex);
    end
    checks++;
    if (alu_result !== 32'd30) begin
      errors++;
      $display("FAIL nop_alu got=%h exp=1e", alu_result);
    end
  endtask

`ifdef MIPS_DECODE_EXEC_OVF_EN
  task automatic test_overflow();
    opcode_id = 6'h00; nop = 1'b0;
    @(posedge clk); #1;
    imm_ex = 32'h20; alu_a = 32'h7FFF_FFFF; alu_b = 32'd1;
    #1;
    checks++;
    if (overflow !== 1'b1 || alu_result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL ovf_add got=%b/%h exp=1/80000000",
               overflow, alu_result);
    end
    imm_ex = 32'h24;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_and got=%b exp=0", overflow);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [11];
    logic [31:0] sp [4];
    logic [5:0] op;
    logic [7:0] exp_ex;
    logic [31:0] b2;
    int k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
            6'h02, 6'h08, 6'h0C, 6'h00, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h00, 6'h3F};
    sp = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 9)];
      opcode_id = op;
      equal = 1'($urandom);
      stall = 1'($urandom);
      nop = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (ctrl_sig !== m_ctrl(op)
          || jump !== (op == 6'h02)
          || branch !== (op == 6'h04)
          || bne !== (op == 6'h05)
          || if_flush !== m_flush(op, equal, stall)) begin
        errors++;
        $display("FAIL rnd_decode op=%h got=%h%b%b%b%b exp=%h%b",
                 op, ctrl_sig, jump, branch, bne, if_flush,
                 m_ctrl(op), m_flush(op, equal, stall));
      end
      exp_ex = (reset || nop) ? 8'h00 : m_ctrl(op);
      @(posedge clk); #1;
      reset = 1'b0;
      alu_a = ($urandom_range(0, 3) == 0) ?
              sp[$urandom_range(0, 3)] : $urandom;
      alu_b = ($urandom_range(0, 3) == 0) ?
              sp[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) alu_b = alu_a;
      imm_ex = {$urandom_range(0, 1) ? 26'h3FF_FFFF : 26'h0,
                fns[$urandom_range(0, 10)]};
      if ($urandom_range(0, 7) == 0) imm_ex = alu_a;
      #1;
      b2 = exp_ex[0] ? imm_ex : alu_b;
      k = m_kind(exp_ex, imm_ex[5:0]);
      checks++;
      if (wb_sig_ex !== exp_ex[7:6] || m_sig_ex !== exp_ex[5:4]
          || reg_dst_ex !== exp_ex[3]) begin
        errors++;
        $display("FAIL rnd_exctl got=%b%b%b exp=%b",
                 wb_sig_ex, m_sig_ex, reg_dst_ex, exp_ex[7:3]);
      end
      checks++;
      if (alu_ctrl !== m_code(k)
          || alu_result !== m_alu(k, alu_a, b2)
          || zero !== (m_alu(k, alu_a, b2) == 32'd0)) begin
        errors++;
        $display("FAIL rnd_alu got=%b/%h/%b exp=%b/%h a=%h b=%h",
                 alu_ctrl, alu_result, zero, m_code(k),
                 m_alu(k, alu_a, b2), alu_a, b2);
      end
`ifdef MIPS_DECODE_EXEC_OVF_EN
      checks++;
      if (overflow !== m_ovf(k, alu_a, b2)) begin
        errors++;
        $display("FAIL rnd_ovf got=%b exp=%b",
                 overflow, m_ovf(k, alu_a, b2));
      end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    opcode_id = 6'h23; nop = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; nop = 1'b0;
    alu_a = 32'd7; alu_b = 32'd9; imm_ex = 32'h100;
    #1;
    checks++;
    if (m_sig_ex !== 2'b00 || alu_result !== 32'd16) begin
      errors++;
      $display("FAIL rst_nop got=%b/%h exp=00/10",
               m_sig_ex, alu_result);
    end
  endtask

  initial begin
    reset = 1'b1; opcode_id = '0; equal = 1'b0; stall = 1'b0;
    nop = 1'b0; alu_a = '0; alu_b = '0; imm_ex = '0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_nop();
`ifdef MIPS_DECODE_EXEC_OVF_EN
    test_overflow();
`endif
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
